// File: rtl/button_event_counter_if.sv
// button_event_counter_if: button inputs and LED/pulse outputs of the press counter.
interface button_event_counter_if;
    logic       BTN_UP;
    logic       BTN_DN;
    logic [7:0] LEDS;
    logic       UP_P;
    logic       DN_P;
    modport master (output BTN_UP, BTN_DN, input LEDS, UP_P, DN_P);
    modport slave (input BTN_UP, BTN_DN, output LEDS, UP_P, DN_P);
endinterface

// File: rtl/button_event_counter.sv
// button_event_counter: debounced up/down push-button press counter shown on 8 LEDs.
// Define BUTTON_COUNTER_SATURATE_EN to saturate at 0/255 instead of wrapping.
module button_event_counter #(
    parameter int N          = 16,
    parameter int DB_SAMPLES = 4
) (
    input logic                   CLK,
    input logic                   RST,
    button_event_counter_if.slave bus
);
    logic [1:0]            btn, s1_q, s2_q, db_q, db_d, dly_q, rise, pulse_q;
    logic [N-1:0]          pre_q;
    logic [DB_SAMPLES-1:0] hist_q [2];
    logic [DB_SAMPLES-1:0] hist_d [2];
    logic [7:0]            cnt_q, cnt_d;
    logic                  tick;
    // index 0 is the up button, index 1 the down button
    assign btn  = {bus.BTN_DN, bus.BTN_UP};
    assign tick = &pre_q;
    assign rise = db_q & ~dly_q;
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            hist_d[i] = tick ? {hist_q[i][DB_SAMPLES-2:0], s2_q[i]} : hist_q[i];
            db_d[i]   = &hist_q[i] ? 1'b1 : ~|hist_q[i] ? 1'b0 : db_q[i];
        end
`ifdef BUTTON_COUNTER_SATURATE_EN
        cnt_d = (rise == 2'b01 && cnt_q != 8'hff) ? cnt_q + 8'd1 :
                (rise == 2'b10 && cnt_q != 8'h00) ? cnt_q - 8'd1 : cnt_q;
`else
        cnt_d = rise == 2'b01 ? cnt_q + 8'd1 : rise == 2'b10 ? cnt_q - 8'd1 : cnt_q;
`endif
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q    <= '0;
            s2_q    <= '0;
            pre_q   <= '0;
            hist_q  <= '{default: '0};
            db_q    <= '0;
            dly_q   <= '0;
            pulse_q <= '0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn;
            s2_q    <= s1_q;
            pre_q   <= pre_q + N'(1);
            hist_q  <= hist_d;
            db_q    <= db_d;
            dly_q   <= db_q;
            pulse_q <= rise;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.LEDS = cnt_q;
    assign bus.UP_P = pulse_q[0];
    assign bus.DN_P = pulse_q[1];
endmodule

// File: tb/tb_button_event_counter.sv
// tb_button_event_counter: randomized scoreboard bench for button_event_counter (N=4, DB_SAMPLES=4).
module tb_button_event_counter;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_cnt = 0;
    typedef struct {
        logic       up;
        logic       dn;
        logic [7:0] leds;
        int         deadline;
    } ev_t;
    ev_t q[$];
    button_event_counter_if bus ();
    button_event_counter #(.N(4), .DB_SAMPLES(4)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    // Every accepted press is a single up/down/both event; the model is count arithmetic.
    task automatic expect_ev(bit up, bit dn, int budget);
        ev_t e;
        if (up && !dn) begin
`ifdef BUTTON_COUNTER_SATURATE_EN
            exp_cnt = exp_cnt == 255 ? 255 : exp_cnt + 1;
`else
            exp_cnt = (exp_cnt + 1) % 256;
`endif
        end else if (dn && !up) begin
`ifdef BUTTON_COUNTER_SATURATE_EN
            exp_cnt = exp_cnt == 0 ? 0 : exp_cnt - 1;
`else
            exp_cnt = (exp_cnt + 255) % 256;
`endif
        end
        e.up = up;
        e.dn = dn;
        e.leds = 8'(exp_cnt);
        e.deadline = cyc + budget;
        q.push_back(e);
    endtask
    always @(negedge clk) begin : monitor
        ev_t e;
        if (!rst && (bus.UP_P || bus.DN_P)) begin
            if (q.size() == 0) check("unexpected_pulse", {30'd0, bus.DN_P, bus.UP_P}, 0);
            else begin
                e = q.pop_front();
                check("pulse_up", bus.UP_P, e.up);
                check("pulse_dn", bus.DN_P, e.dn);
                check("leds_at_pulse", bus.LEDS, e.leds);
                check("latency_in_budget", cyc <= e.deadline, 1);
            end
        end
    end
    task automatic drive(bit up, bit dn);
        bus.BTN_UP = up;
        bus.BTN_DN = dn;
    endtask
    task automatic wait_n(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0);
        wait_n(3);
        rst = 1'b0;
        q.delete();
        exp_cnt = 0;
    endtask
    task automatic drain(string nm);
        for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
        check(nm, q.size(), 0);
    endtask
    // bounce cycles precede the stable hold; periodic bounce flips every 3 cycles
    task automatic press(bit up, bit dn, int bounce, bit periodic, int hold, int rel, int glitch);
        expect_ev(up, dn, bounce + 72);
        for (int i = 0; i < bounce; i++) begin
            bit v;
            v = periodic ? ((i / 3) % 2 == 0) : 1'($urandom_range(0, 1));
            drive(up & v, dn & v);
            @(negedge clk);
        end
        drive(up, dn);
        wait_n(hold);
        drive(0, 0);
        wait_n(rel);
        if (glitch > 0) begin
            drive(up, dn);
            wait_n(glitch);
            drive(0, 0);
            wait_n(20);
        end
        drain("press_delivered");
        check("leds_after_press", bus.LEDS, exp_cnt);
    endtask
    initial begin
        rst = 1'b1;
        drive(1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_leds", bus.LEDS, 0);
            check("rst_up_p", bus.UP_P, 0);
        end
        rst = 1'b0;
        exp_cnt = 0;
        expect_ev(1, 0, 68);
        wait_n(150);
        drive(0, 0);
        wait_n(150);
        drain("rst_held_press");
        check("rst_held_leds", bus.LEDS, 1);
        do_reset();
        for (int i = 0; i < 3; i++) press(1, 0, 0, 0, 200, 200, 0);
        check("clean_x3", bus.LEDS, 3);
        do_reset();
        press(1, 0, 60, 1, 150, 200, 0);
        check("bounce_once", bus.LEDS, 1);
        do_reset();
        drive(1, 0);
        wait_n(10);
        drive(0, 0);
        wait_n(150);
        check("glitch_ignored", bus.LEDS, 0);
        check("glitch_queue", q.size(), 0);
        do_reset();
        press(0, 1, 0, 0, 200, 200, 0);
`ifdef BUTTON_COUNTER_SATURATE_EN
        check("wrap_down", bus.LEDS, 0);
`else
        check("wrap_down", bus.LEDS, 255);
`endif
        press(1, 0, 0, 0, 200, 200, 0);
`ifdef BUTTON_COUNTER_SATURATE_EN
        check("wrap_up", bus.LEDS, 1);
`else
        check("wrap_up", bus.LEDS, 0);
`endif
        do_reset();
        for (int i = 0; i < 5; i++) press(1, 0, 0, 0, 100, 100, 0);
        press(1, 1, 0, 0, 200, 200, 0);
        check("simultaneous_leds", bus.LEDS, 5);
        do_reset();
        for (int i = 0; i < 7; i++) press(1, 0, 0, 0, 100, 100, 0);
        check("pre_rst_leds", bus.LEDS, 7);
        for (int i = 0; i < 30; i++) begin
            drive(0, (i / 3) % 2 == 0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_leds", bus.LEDS, 0);
        drive(0, 0);
        wait_n(2);
        rst = 1'b0;
        q.delete();
        exp_cnt = 0;
        wait_n(150);
        check("rst_mid_after", bus.LEDS, 0);
        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            press(kind != 1, kind != 0, $urandom_range(0, 1) ? $urandom_range(1, 50) : 0, 0,
                  $urandom_range(90, 200), $urandom_range(90, 200),
                  $urandom_range(0, 1) ? $urandom_range(1, 10) : 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/button_event_counter.md
Name: button_event_counter

Overview:
- Input-side counterpart to the free-running LED counter: reads two raw mechanical push-buttons (up/down) and counts presses.
- Each button goes through a 2-FF synchronizer, a prescaled-tick debouncer and a rising-edge detector, then drives an 8-bit up/down counter shown on the LEDs.
- Single clock domain on CLK; the buttons are the only asynchronous inputs.

Parameters:
- N, 16, prescaler width; debounce sample tick every 2^N CLK cycles.
- DB_SAMPLES, 4, consecutive equal tick samples required to change debounced state (min 2).

Ports:
- CLK  input  1  system clock
- RST  input  1  synchronous reset, active-high
- BTN_UP  input  1  raw up button, active-high, asynchronous, may bounce
- BTN_DN  input  1  raw down button, active-high, asynchronous, may bounce
- LEDS  output  8  current count, LEDS[7] = MSB
- UP_P  output  1  one-cycle pulse on each accepted up press
- DN_P  output  1  one-cycle pulse on each accepted down press

Behaviour:
- Reset (RST high at a CLK edge) clears all state to 0: sync FFs, prescaler, history, debounced state, delayed state, count. Outputs after reset: LEDS=0, UP_P=0, DN_P=0.
- Synchronizer: per button, two flops; s1<=BTN, s2<=s1. Only s2 is used downstream.
- Prescaler:
  - N-bit counter, +1 every cycle, wraps.
  - tick=1 combinationally when prescaler == all ones. The first tick after reset occurs in cycle 2^N-1.
- History: per button, DB_SAMPLES-bit shift register; on tick, hist <= {hist[DB_SAMPLES-2:0], s2}. Otherwise it holds.
- Debounced state db, updated every cycle:
  - db<=1 if hist all ones.
  - db<=0 if hist all zeros.
  - Otherwise db holds.
- Edge detect: db_d<=db each cycle; rise = db & ~db_d. The release edge is ignored.
- UP_P and DN_P are registered: UP_P<=rise_up, DN_P<=rise_dn. Each is high exactly one cycle per accepted press.
- Count update (same edge as UP_P/DN_P registering):
  - rise_up only: count+1.
  - rise_dn only: count-1.
  - Both or neither: unchanged.
- Width/wrap: 8-bit modulo arithmetic; 255+1 -> 0, 0-1 -> 255 (see SATURATE_EN). LEDS = count directly, no extra latency.
- Latency from a clean stable edge on BTN_x to the LEDS change:
  - 2 sync cycles, plus up to DB_SAMPLES ticks (worst case DB_SAMPLES*2^N), plus 2 cycles (db, then count/pulse).
- Boundary conditions:
  - Any bounce shorter than DB_SAMPLES consecutive equal samples produces no event.
  - Holding a button indefinitely counts once.
  - Both buttons pressed in the same cycle: UP_P=DN_P=1, count unchanged.
  - RST mid-press: all state clears. If the button is still held after RST falls, it is re-debounced and counts as one new press.
  - RST has priority over every event in the same cycle.

Optional Feature:
- Macro: BUTTON_COUNTER_SATURATE_EN.
- Defined: count saturates; up at 255 stays 255 and down at 0 stays 0. UP_P/DN_P still pulse on accepted presses.
- Undefined: modulo-256 wrap as specified above.

Test Plan:
- All scenarios use N=4 (tick every 16 cycles) and DB_SAMPLES=4.
- Reset: hold RST 3 cycles with BTN_UP=1 -> LEDS=0, UP_P=0 during reset. After release, exactly one UP_P within 2+64+2 cycles; LEDS=1.
- Clean press: BTN_UP high 200 cycles, then low 200 cycles -> exactly one UP_P, LEDS 0->1, no change on release. Repeat 3 times -> LEDS=3.
- Bounce: BTN_UP toggles every 3 cycles for 60 cycles, then held high 150 cycles -> exactly one UP_P, LEDS=1. A 10-cycle glitch alone -> no pulse, LEDS=0.
- Wrap: from reset, one clean BTN_DN press -> DN_P once, LEDS=255; then one BTN_UP press -> LEDS=0. With BUTTON_COUNTER_SATURATE_EN: LEDS stays 0 after the down press, goes to 1 after the up press.
- Simultaneous: preset LEDS=5 via 5 up presses; drive BTN_UP and BTN_DN with identical 200-cycle pulses -> UP_P and DN_P high in the same cycle, LEDS stays 5.
- Reset mid-operation: at LEDS=7, assert RST while BTN_DN is bouncing -> LEDS=0 next cycle. Release RST with BTN_DN low -> no pulse, LEDS remains 0.
